// File: rtl/tdc_pkg.sv
// Shared TDC definitions: sample width, sample and drop-count types, and the
// phase encoding of the block-average frame.
package tdc_pkg;

  localparam int TDC_DW = 20;

  typedef logic signed [TDC_DW-1:0] tdc_sample_t;
  typedef logic [7:0]               drop_cnt_t;

  typedef enum logic {
    PH_ACC,
    PH_LAST
  } phase_t;

  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (v == '1) ? v : v + drop_cnt_t'(1);
  endfunction

endpackage

// File: rtl/tdc_avg_if.sv
// Result stream toward the readout side: FIFO head with a valid/ready handshake.
interface tdc_avg_if #(
  parameter int DW = 20
);
  logic signed [DW-1:0] o_data;
  logic                 o_valid;
  logic                 o_ready;

  modport master (output o_data, output o_valid, input o_ready);
  modport slave  (input o_data, input o_valid, output o_ready);
endinterface

// File: rtl/tdc_avg_fifo.sv
// Synchronous result FIFO with a registered show-ahead head; push and pop may
// coincide when full or empty. clr empties it and suppresses any pop.
module tdc_avg_fifo #(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  always_comb begin
    empty   = (cnt == '0);
    full    = (cnt == (AW+1)'(DEPTH));
    do_pop  = pop & ~empty & ~clr;
    do_push = push & (~full | do_pop) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      dout <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      // Head register tracks mem[rp]; a push into an empty (or emptying) FIFO
      // bypasses the array. When the FIFO drains the old head is held.
      if (do_pop) begin
        if (cnt > (AW+1)'(1)) dout <= mem[rp + AW'(1)];
        else if (do_push)     dout <= din;
      end else if (do_push && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/tdc_avg.sv
// Decimating block averager: sums 2^LOG2N signed samples and queues the mean
// in an output FIFO, counting results dropped on overflow.
// Optional TDC_AVG_ROUND_EN: round half up instead of flooring.
module tdc_avg
  import tdc_pkg::*;
#(
  parameter int DW     = TDC_DW,
  parameter int LOG2N  = 4,
  parameter int FDEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_dval,
  input  logic signed [DW-1:0] i_data,
  input  logic                 clr,
  tdc_avg_if.master            rd,
  output logic                 o_ovf,
  output drop_cnt_t            o_drop
);
  localparam int AW = DW + LOG2N;
  localparam int CW = (LOG2N > 0) ? LOG2N : 1;
  localparam int N  = 1 << LOG2N;

  typedef logic signed [AW-1:0] acc_t;

`ifdef TDC_AVG_ROUND_EN
  localparam acc_t RND = AW'((1 << LOG2N) >> 1);
`else
  localparam acc_t RND = '0;
`endif

  acc_t                 acc, sum, sum_r;
  logic [CW-1:0]        cnt;
  phase_t               phase;
  logic                 res_vld;
  logic signed [DW-1:0] res_data;
  logic [DW-1:0]        head;
  logic                 full, empty, pop;

  always_comb begin
    phase = (cnt == CW'(N - 1)) ? PH_LAST : PH_ACC;
    sum   = acc + AW'(i_data);
    sum_r = sum + RND;
    pop   = rd.o_valid & rd.o_ready;
  end

  assign rd.o_valid = ~empty;
  assign rd.o_data  = head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      res_vld  <= 1'b0;
      res_data <= '0;
      o_ovf    <= 1'b0;
      o_drop   <= '0;
    end else if (clr) begin
      acc     <= '0;
      cnt     <= '0;
      res_vld <= 1'b0;
      o_ovf   <= 1'b0;
      o_drop  <= '0;
    end else begin
      res_vld <= 1'b0;
      if (i_dval) begin
        if (phase == PH_LAST) begin
          res_data <= DW'(sum_r >>> LOG2N);
          res_vld  <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
      // A pending result is lost only if the FIFO is full and not popping now.
      if (res_vld && full && !pop) begin
        o_ovf  <= 1'b1;
        o_drop <= sat_inc(o_drop);
      end
    end
  end

  tdc_avg_fifo #(
    .DW    (DW),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (res_vld),
    .din   (res_data),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_tdc_avg.sv
// Self-checking bench for tdc_avg: expected averages are queued as frames are
// driven and compared in order as the DUT hands results out.
module tb_tdc_avg;
  import tdc_pkg::*;

  localparam int  DW     = TDC_DW;
  localparam int  LOG2N  = 4;
  localparam int  FDEPTH = 4;
  localparam int  N      = 1 << LOG2N;
`ifdef TDC_AVG_ROUND_EN
  localparam longint RND = (1 << LOG2N) >> 1;
`else
  localparam longint RND = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_dval = 1'b0;
  tdc_sample_t i_data = '0;
  logic        clr = 1'b0;
  logic        o_ovf;
  drop_cnt_t   o_drop;

  int total = 0;
  int bad   = 0;
  longint expq[$];

  tdc_avg_if #(.DW(DW)) rd ();

  tdc_avg #(
    .DW     (DW),
    .LOG2N  (LOG2N),
    .FDEPTH (FDEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_dval (i_dval),
    .i_data (i_data),
    .clr    (clr),
    .rd     (rd),
    .o_ovf  (o_ovf),
    .o_drop (o_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && !clr && rd.o_valid && rd.o_ready) begin
      if (expq.size() == 0) chk("unexpected_out", longint'(rd.o_valid), 0);
      else                  chk("data", longint'(rd.o_data), expq.pop_front());
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that samples it.
  task automatic send(input longint v, input int gap);
    i_dval = 1'b1;
    i_data = DW'(v);
    @(posedge clk); #1;
    i_dval = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input longint base, input longint step, input int gap, input bit keep);
    longint s = 0;
    for (int i = 0; i < N; i++) begin
      s += base + i * step;
      send(base + i * step, (i == N - 1) ? 1 : gap);
    end
    if (keep) expq.push_back((s + RND) >>> LOG2N);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    chk("drain_left", expq.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_valid", longint'(rd.o_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rd.o_ready = 1'b1;
    #3;
    chk("rst_data",  longint'(rd.o_data), 0);
    chk("rst_valid", longint'(rd.o_valid), 0);
    chk("rst_ovf",   longint'(o_ovf), 0);
    chk("rst_drop",  longint'(o_drop), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Constant frame with spaced strobes, plus result latency.
    send_frame(100, 0, 3, 1'b1);
    chk("lat_k",  longint'(rd.o_valid), 0);
    @(posedge clk); #1;
    chk("lat_k1", longint'(rd.o_valid), 1);
    wait_drain(20);

    send_frame(0, 1, 1, 1'b1);           // 0..15 -> 7 (8 rounded)
    send_frame(-3, 0, 2, 1'b1);          // -3 in both builds
    send_frame(20'sh7FFFF, 0, 1, 1'b1);
    send_frame(-524288, 0, 1, 1'b1);     // 0x80000
    wait_drain(40);

    // Backpressure: six frames, four held, two dropped.
    rd.o_ready = 1'b0;
    for (int f = 0; f < 6; f++) send_frame(100 * (f + 1), 0, 1, f < FDEPTH);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_drop",  longint'(o_drop), 2);
    chk("bp_ovf",   longint'(o_ovf), 1);
    chk("bp_valid", longint'(rd.o_valid), 1);
    rd.o_ready = 1'b1;
    for (int i = 0; i < FDEPTH; i++) begin
      @(negedge clk);
      chk("burst_valid", longint'(rd.o_valid), 1);
    end
    @(negedge clk);
    chk("burst_end", longint'(rd.o_valid), 0);
    @(posedge clk); #1;
    wait_drain(20);

    // Async reset mid-frame and mid-pop.
    rd.o_ready = 1'b0;
    send_frame(40, 0, 1, 1'b1);
    send_frame(50, 0, 1, 1'b1);
    for (int i = 0; i < 7; i++) send(5000, 1);
    rd.o_ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_data",  longint'(rd.o_data), 0);
    chk("arst_valid", longint'(rd.o_valid), 0);
    chk("arst_ovf",   longint'(o_ovf), 0);
    chk("arst_drop",  longint'(o_drop), 0);
    expq.delete();
    @(posedge clk); #1;
    i_dval = 1'b1; i_data = 20'sd9999;
    @(posedge clk); #1;
    i_dval = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(-77, 0, 1, 1'b1);
    wait_drain(20);

    // Saturating drop count, then clr mid-frame with a coincident strobe.
    rd.o_ready = 1'b0;
    for (int f = 0; f < 260; f++) send_frame(7, 0, 1, 1'b0);
    @(posedge clk); #1;
    chk("sat_drop", longint'(o_drop), 255);
    chk("sat_ovf",  longint'(o_ovf), 1);
    for (int i = 0; i < 9; i++) send(1000, 1);
    clr = 1'b1; i_dval = 1'b1; i_data = 20'sd1000;
    @(posedge clk); #1;
    clr = 1'b0; i_dval = 1'b0;
    chk("clr_valid", longint'(rd.o_valid), 0);
    chk("clr_ovf",   longint'(o_ovf), 0);
    chk("clr_drop",  longint'(o_drop), 0);
    rd.o_ready = 1'b1;
    send_frame(5, 0, 1, 1'b1);
    wait_drain(20);

    // Full FIFO with a pop coinciding with the push: nothing dropped.
    rd.o_ready = 1'b0;
    for (int f = 0; f < FDEPTH; f++) send_frame(11 * (f + 1), 1, 1, 1'b1);
    send_frame(-55, 2, 1, 1'b1);
    rd.o_ready = 1'b1;
    @(posedge clk); #1;
    rd.o_ready = 1'b0;
    chk("same_drop",  longint'(o_drop), 0);
    chk("same_ovf",   longint'(o_ovf), 0);
    chk("same_valid", longint'(rd.o_valid), 1);
    rd.o_ready = 1'b1;
    wait_drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
